// File: rtl/switch_input_conditioner.sv
// Synchronizes and debounces SW[3:0] and BTNC, then drives the decoder select/enable.
// Optional macro COND_LATCH_EN: dec_w/dec_en latch on each button press instead of passing through.
module switch_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] SW,
  input  logic       BTNC,
  output logic [3:0] sw_clean,
  output logic       btn_level,
  output logic       btn_rise,
  output logic [3:0] dec_w,
  output logic       dec_en
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0] sync_q [SYNC_STAGES];
  logic [3:0] sw_s;
  logic       btn_s;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {SW, BTNC};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_s  = sync_q[SYNC_STAGES-1][4:1];
  assign btn_s = sync_q[SYNC_STAGES-1][0];

  logic [3:0]       a_prev, a_clean, a_clean_d;
  logic [CNT_W-1:0] a_cnt, a_cnt_d;
  logic             b_prev, b_clean, b_clean_d;
  logic [CNT_W-1:0] b_cnt, b_cnt_d;
  logic             rise_q;

  // Channel A treats the switch bus as one word so mixed values never pass.
  always_comb begin
    a_cnt_d   = a_cnt;
    a_clean_d = a_clean;
    if (sw_s == a_clean) begin
      a_cnt_d = '0;
    end else if (sw_s != a_prev) begin
      a_cnt_d = '0;
    end else if (a_cnt == LAST) begin
      a_clean_d = sw_s;
      a_cnt_d   = '0;
    end else begin
      a_cnt_d = a_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    b_cnt_d   = b_cnt;
    b_clean_d = b_clean;
    if (btn_s == b_clean) begin
      b_cnt_d = '0;
    end else if (btn_s != b_prev) begin
      b_cnt_d = '0;
    end else if (b_cnt == LAST) begin
      b_clean_d = btn_s;
      b_cnt_d   = '0;
    end else begin
      b_cnt_d = b_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      a_prev  <= '0;
      a_cnt   <= '0;
      a_clean <= '0;
      b_prev  <= 1'b0;
      b_cnt   <= '0;
      b_clean <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      a_prev  <= sw_s;
      a_cnt   <= a_cnt_d;
      a_clean <= a_clean_d;
      b_prev  <= btn_s;
      b_cnt   <= b_cnt_d;
      b_clean <= b_clean_d;
      rise_q  <= b_clean_d & ~b_clean;
    end
  end

  assign sw_clean  = a_clean;
  assign btn_level = b_clean;
  assign btn_rise  = rise_q;

`ifdef COND_LATCH_EN
  logic [3:0] w_q;
  logic       en_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      w_q  <= '0;
      en_q <= 1'b0;
    end else if (rise_q) begin
      w_q  <= a_clean;
      en_q <= ~en_q;
    end
  end

  assign dec_w  = w_q;
  assign dec_en = en_q;
`else
  assign dec_w  = a_clean;
  assign dec_en = b_clean;
`endif

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output snapshots per cycle,
// a negedge monitor compares them and flags any unannounced output change.
module tb_switch_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btnc;
  logic [3:0] sw_clean;
  logic       btn_level;
  logic       btn_rise;
  logic [3:0] dec_w;
  logic       dec_en;

  switch_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .SW(sw),
    .BTNC(btnc),
    .sw_clean(sw_clean),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .dec_w(dec_w),
    .dec_en(dec_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] sw;
    logic       lvl;
    logic       rise;
    logic [3:0] w;
    logic       en;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nerr = 0;

  logic [3:0] cur_sw = 4'h0;
  logic       cur_lvl = 1'b0;
  logic [3:0] lw = 4'h0;
  logic       len = 1'b0;

  task automatic push(input int at, input logic rise);
    exp_t e;
    e.cyc  = at;
    e.sw   = cur_sw;
    e.lvl  = cur_lvl;
    e.rise = rise;
`ifdef COND_LATCH_EN
    e.w  = lw;
    e.en = len;
`else
    e.w  = cur_sw;
    e.en = cur_lvl;
`endif
    sbq.push_back(e);
  endtask

  task automatic rise_at(input int r);
    push(r, 1'b1);
    lw  = cur_sw;
    len = ~len;
    push(r + 1, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [10:0] last = '0;

  always @(negedge clk) begin
    automatic logic [10:0] cur = {sw_clean, btn_level, btn_rise, dec_w, dec_en};
    automatic exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      ncmp++;
      nerr++;
      $display("FAIL missed_check cyc=%0d expected_at=%0d", cyc, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      ncmp++;
      if (cur != {e.sw, e.lvl, e.rise, e.w, e.en}) begin
        nerr++;
        $display("FAIL snapshot cyc=%0d got sw=%h lvl=%b rise=%b w=%h en=%b want sw=%h lvl=%b rise=%b w=%h en=%b",
                 cyc, sw_clean, btn_level, btn_rise, dec_w, dec_en,
                 e.sw, e.lvl, e.rise, e.w, e.en);
      end
    end else if (cur != last) begin
      ncmp++;
      nerr++;
      $display("FAIL unexpected_change cyc=%0d got %h was %h", cyc, cur, last);
    end
    last = cur;
  end

  int k;

  initial begin
    rst_n = 1'b0;
    sw    = 4'hF;
    btnc  = 1'b1;
    // Reset with inputs already high
    tick(2);
    k = cyc;
    push(k + 1, 1'b0);
    tick(2);
    rst_n = 1'b1;
    k = cyc;
    push(k + 1, 1'b0);
    push(k + 6, 1'b0);
    cur_sw  = 4'hF;
    cur_lvl = 1'b1;
    rise_at(k + 7);
    tick(10);

    // Both inputs back to 0; debounced release gives no pulse
    sw   = 4'h0;
    btnc = 1'b0;
    k = cyc;
    cur_sw  = 4'h0;
    cur_lvl = 1'b0;
    push(k + 7, 1'b0);
    tick(10);

    // Switch step 0 -> A
    sw = 4'hA;
    k = cyc;
    push(k + 6, 1'b0);
    cur_sw = 4'hA;
    push(k + 7, 1'b0);
    tick(10);

    // Bouncing button never accepted
    for (int i = 0; i < 2; i++) begin
      btnc = 1'b1;
      tick(3);
      btnc = 1'b0;
      tick(3);
    end
    tick(10);
    k = cyc;
    push(k + 1, 1'b0);
    tick(3);

    // Clean 10-cycle press
    btnc = 1'b1;
    k = cyc;
    cur_lvl = 1'b1;
    rise_at(k + 7);
    tick(10);
    btnc = 1'b0;
    cur_lvl = 1'b0;
    push(k + 17, 1'b0);
    tick(12);

    // Skewed switch bits: 0 -> 1 -> 3
    sw = 4'h0;
    k = cyc;
    cur_sw = 4'h0;
    push(k + 7, 1'b0);
    tick(10);
    sw = 4'h1;
    k = cyc;
    tick(2);
    sw = 4'h3;
    cur_sw = 4'h3;
    push(k + 9, 1'b0);
    tick(12);

    // Reset mid-count
    sw = 4'h0;
    k = cyc;
    cur_sw = 4'h0;
    push(k + 7, 1'b0);
    tick(10);
    sw = 4'h7;
    k = cyc;
    tick(3);
    #2 rst_n = 1'b0;
    lw  = 4'h0;
    len = 1'b0;
    push(k + 4, 1'b0);
    tick(2);
    #2 rst_n = 1'b1;
    push(k + 11, 1'b0);
    cur_sw = 4'h7;
    push(k + 12, 1'b0);
    tick(12);

    // Press/hold sequence for the latch behaviour
    sw = 4'h5;
    k = cyc;
    cur_sw = 4'h5;
    push(k + 7, 1'b0);
    tick(10);
    for (int p = 0; p < 2; p++) begin
      btnc = 1'b1;
      k = cyc;
      cur_lvl = 1'b1;
      rise_at(k + 7);
      tick(10);
      btnc = 1'b0;
      cur_lvl = 1'b0;
      push(k + 17, 1'b0);
      tick(12);
      if (p == 0) begin
        sw = 4'h9;
        k = cyc;
        cur_sw = 4'h9;
        push(k + 7, 1'b0);
        tick(10);
      end
    end

    tick(3);
    ncmp++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL leftover_checks got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
